// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath/memory.
// The master side is the sequencer; the slave side is the datapath and memory.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_ctrl;
  logic [1:0]       imm_src;
  logic [1:0]       result_src;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src,
           illegal, retire, retire_cnt
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src,
           illegal, retire, retire_cnt
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: time-shares one ALU and one unified memory
// over fetch/decode/execute/memory/writeback and counts retired instructions.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  mc_ctrl_if.master  bus
);

  localparam int unsigned OP_W = 7;
  localparam int unsigned F3_W = 3;
  localparam int unsigned F7_W = 7;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_LDWB   = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BEQ    = 4'd10,
    S_ILL    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  retire_cnt_q;

  logic [OP_W-1:0]   op;
  logic [F3_W-1:0]   funct3;
  logic [F7_W-1:0]   funct7;
  logic              unused_instr;

  assign op           = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign funct7       = bus.instr[31:25];
  assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

  // R-type and I-type ALU function decode; *_ok clear means unsupported.
  logic       r_ok, i_ok;
  logic [2:0] r_alu, i_alu;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (funct7 == F7_BASE)     r_alu = ALU_ADD;
        else if (funct7 == F7_ALT) r_alu = ALU_SUB;
        else                       r_ok  = 1'b0;
      end
      3'b111:  begin r_alu = ALU_AND; r_ok = (funct7 == F7_BASE); end
      3'b110:  begin r_alu = ALU_OR;  r_ok = (funct7 == F7_BASE); end
      3'b100:  begin r_alu = ALU_XOR; r_ok = (funct7 == F7_BASE); end
      default: r_ok = 1'b0;
    endcase

    i_ok  = 1'b1;
    i_alu = ALU_ADD;
    case (funct3)
      3'b000:  i_alu = ALU_ADD;
      3'b111:  i_alu = ALU_AND;
      3'b110:  i_alu = ALU_OR;
      3'b100:  i_alu = ALU_XOR;
      default: i_ok  = 1'b0;
    endcase
  end

  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_ctrl;
  logic       illegal, retire;

  // Next-state and per-state control decode; anything not driven stays 0.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    imm_src    = 2'b00;
    result_src = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      // Speculatively forms the branch target into ALUOut while decoding.
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        if (op == OP_LOAD || op == OP_STORE)         state_d = S_MEMADR;
        else if (op == OP_RTYPE)                     state_d = S_EXEC_R;
        else if (op == OP_ITYPE)                     state_d = S_EXEC_I;
        else if (op == OP_BRANCH && funct3 == 3'b000) state_d = S_BEQ;
        else                                         state_d = S_ILL;
      end

      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_STORE) ? 2'b01 : 2'b00;
        state_d   = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_LDWB;
      end

      S_LDWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 2'b10;
        if (r_ok) begin
          alu_ctrl = r_alu;
          state_d  = S_ALUWB;
        end else begin
          state_d  = S_ILL;
        end
      end

      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (i_ok) begin
          alu_ctrl = i_alu;
          state_d  = S_ALUWB;
        end else begin
          state_d  = S_ILL;
        end
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_write  = bus.zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_ILL: begin
        illegal = 1'b1;
        state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RST;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.adr_src    = adr_src;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.imm_src    = imm_src;
  assign bus.result_src = result_src;
  assign bus.illegal    = illegal;
  assign bus.retire     = retire;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a memory responder issues instructions with random
// waits and pushes per-instruction expectations; a monitor checks each completed instruction.
module tb_mc_ctrl_fsm;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_nh = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CW)) bus ();
  mc_ctrl_if #(.CNT_W(32)) bus_h ();

  mc_ctrl_fsm #(.CNT_W(CW), .ILLEGAL_HALT(1'b0)) dut   (.clk(clk), .rst_n(rst_n),  .bus(bus));
  mc_ctrl_fsm #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut_h (.clk(clk), .rst_n(rst_nh), .bus(bus_h));

  logic [19:0] ov, ov_h;
  assign ov   = {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write,
                 bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.imm_src, bus.result_src,
                 bus.illegal, bus.retire};
  assign ov_h = {bus_h.mem_req, bus_h.mem_we, bus_h.adr_src, bus_h.ir_write, bus_h.pc_write,
                 bus_h.reg_write, bus_h.alu_src_a, bus_h.alu_src_b, bus_h.alu_ctrl,
                 bus_h.imm_src, bus_h.result_src, bus_h.illegal, bus_h.retire};

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          dw;
    logic        z;
  } stim_t;

  typedef struct {
    int cycles;
    int illegal;
    int retire;
    int rw;
    int we;
    int pcw;
    int alu;
    int chk_alu;
    int imm;
    int res;
  } exp_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Per-instruction summary from the ISA rules: CPI plus waits, side effects, ALU op.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         alu;
    bit         ok;
    op = s.ins[6:0];
    f3 = s.ins[14:12];
    f7 = s.ins[31:25];
    e  = '{default: 0};
    ok = 1'b1;
    alu = 0;
    case (op)
      7'h03: begin e.cycles = 5 + s.fw + s.dw; e.rw = 1; e.res = 1; end
      7'h23: begin e.cycles = 4 + s.fw + s.dw; e.we = 1 + s.dw; e.imm = 1; end
      7'h33: begin
        e.cycles = 4 + s.fw;
        if (f3 == 3'd0 && f7 == 7'h00)      alu = 0;
        else if (f3 == 3'd0 && f7 == 7'h20) alu = 1;
        else if (f3 == 3'd7 && f7 == 7'h00) alu = 2;
        else if (f3 == 3'd6 && f7 == 7'h00) alu = 3;
        else if (f3 == 3'd4 && f7 == 7'h00) alu = 4;
        else ok = 1'b0;
        e.rw = 1;
      end
      7'h13: begin
        e.cycles = 4 + s.fw;
        if (f3 == 3'd0)      alu = 0;
        else if (f3 == 3'd7) alu = 2;
        else if (f3 == 3'd6) alu = 3;
        else if (f3 == 3'd4) alu = 4;
        else ok = 1'b0;
        e.rw = 1;
      end
      7'h63: begin
        e.cycles = 3 + s.fw;
        ok = (f3 == 3'd0);
        alu = 1;
        e.pcw = int'(s.z);
      end
      default: begin e.cycles = 3 + s.fw; ok = 1'b0; end
    endcase
    if (ok) begin
      e.retire  = 1;
      e.alu     = alu;
      e.chk_alu = 1;
    end else begin
      e = '{default: 0};
      e.cycles  = (op == 7'h33 || op == 7'h13) ? 4 + s.fw : 3 + s.fw;
      e.illegal = 1;
    end
    return e;
  endfunction

  // Memory responder and IR model; issues each instruction as it is fetched.
  stim_t nxt, cur;
  bit    have_nxt = 1'b0;
  bit    load_pending = 1'b0;
  int    fcnt = 0, dcnt = 0;

  initial begin : driver
    bus.mem_ready = 1'b0;
    bus.instr     = 32'h0;
    bus.zero      = 1'b0;
    cur           = '{ins: 32'h0, fw: 0, dw: 0, z: 1'b0};
    nxt           = cur;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        have_nxt      = 1'b0;
        load_pending  = 1'b0;
        bus.mem_ready = 1'b0;
        continue;
      end
      if (load_pending) begin
        bus.instr = nxt.ins;
        bus.zero  = nxt.z;
        cur       = nxt;
        sb_q.push_back(model(nxt));
        load_pending = 1'b0;
        have_nxt     = 1'b0;
        dcnt         = 0;
      end
      if (bus.mem_req && !bus.adr_src) begin
        if (!have_nxt && stim_q.size() > 0) begin
          nxt      = stim_q.pop_front();
          have_nxt = 1'b1;
          fcnt     = 0;
        end
        if (!have_nxt) bus.mem_ready = 1'b0;
        else if (fcnt < nxt.fw) begin bus.mem_ready = 1'b0; fcnt++; end
        else begin bus.mem_ready = 1'b1; load_pending = 1'b1; end
      end else if (bus.mem_req) begin
        if (dcnt < cur.dw) begin bus.mem_ready = 1'b0; dcnt++; end
        else bus.mem_ready = 1'b1;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
    end
  end

  // Monitor: accumulates what the DUT did per instruction and scores it on completion.
  bit         active = 1'b0;
  int         m_cyc, m_irw, m_rw, m_we, m_pcw, m_alu, m_imm;
  int         exp_cnt = 0;
  bit         prev_wait = 1'b0;
  logic       prev_adr, prev_we;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      active    = 1'b0;
      sb_q.delete();
      exp_cnt   = 0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait)
        check("req_held", {bus.mem_req, bus.adr_src, bus.mem_we}, {1'b1, prev_adr, prev_we});
      prev_wait = bus.mem_req && !bus.mem_ready;
      prev_adr  = bus.adr_src;
      prev_we   = bus.mem_we;
      if (!active && bus.mem_req && !bus.adr_src) begin
        active = 1'b1;
        m_cyc = 0; m_irw = 0; m_rw = 0; m_we = 0; m_pcw = 0; m_alu = 0; m_imm = 0;
      end
      if (active) begin
        m_cyc++;
        if (bus.ir_write)  m_irw++;
        if (bus.reg_write) m_rw++;
        if (bus.mem_we)    m_we++;
        if (bus.pc_write && !(bus.mem_req && !bus.adr_src)) m_pcw = 1;
        if (bus.alu_src_a == 2'b10) begin m_alu = int'(bus.alu_ctrl); m_imm = int'(bus.imm_src); end
        if (bus.retire || bus.illegal) begin
          if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("cycles",   m_cyc, e.cycles);
            check("illegal",  bus.illegal, e.illegal);
            check("retire",   bus.retire, e.retire);
            check("ir_write", m_irw, 1);
            check("reg_wr",   m_rw, e.rw);
            check("mem_we",   m_we, e.we);
            check("pc_wr",    m_pcw, e.pcw);
            check("imm_src",  m_imm, e.imm);
            check("res_src",  bus.result_src, e.res);
            if (e.chk_alu != 0) check("alu_ctrl", m_alu, e.alu);
          end
          active = 1'b0;
        end
      end
      if (bus.retire) begin
        check("retire_cnt", bus.retire_cnt, exp_cnt);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
    end
  end

  int h_ill = 0, h_ret = 0, h_irw = 0;
  always @(negedge clk) begin
    if (rst_nh) begin
      if (bus_h.illegal)  h_ill++;
      if (bus_h.retire)   h_ret++;
      if (bus_h.ir_write) h_irw++;
    end
  end

  function automatic stim_t rnd_stim();
    stim_t s;
    int    k;
    s.ins = $urandom;
    s.fw  = $urandom_range(0, 3);
    s.dw  = $urandom_range(0, 3);
    s.z   = 1'($urandom);
    k = $urandom_range(0, 5);
    case (k)
      0: s.ins[6:0] = 7'h03;
      1: s.ins[6:0] = 7'h23;
      2: begin
        s.ins[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: s.ins[31:25] = 7'h00;
          1: s.ins[31:25] = 7'h20;
          default: ;
        endcase
      end
      3: s.ins[6:0] = 7'h13;
      4: begin
        s.ins[6:0] = 7'h63;
        if ($urandom_range(0, 3) != 0) s.ins[14:12] = 3'd0;
      end
      default: ;
    endcase
    return s;
  endfunction

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (stim_q.size() == 0 && !have_nxt && sb_q.size() == 0 && !active) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(nm, done, 1'b1);
  endtask

  initial begin : main
    bit seen;
    bus_h.instr     = 32'h0000007F;
    bus_h.zero      = 1'b0;
    bus_h.mem_ready = 1'b1;

    stim_q.push_back('{ins: 32'h002081B3, fw: 0, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'h0080A283, fw: 3, dw: 3, z: 1'b0});
    stim_q.push_back('{ins: 32'h00208463, fw: 0, dw: 0, z: 1'b1});
    stim_q.push_back('{ins: 32'h00208463, fw: 1, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'h402081B3, fw: 0, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'h0020F1B3, fw: 0, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'h0020E1B3, fw: 2, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'h0020C1B3, fw: 0, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'h0020A423, fw: 0, dw: 2, z: 1'b0});
    stim_q.push_back('{ins: 32'h0000007F, fw: 0, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'h002091B3, fw: 1, dw: 0, z: 1'b0});
    stim_q.push_back('{ins: 32'hFFF08093, fw: 0, dw: 0, z: 1'b0});
    for (int i = 0; i < 40; i++) stim_q.push_back(rnd_stim());

    #1;
    check("rst_outs",   ov, 20'h0);
    check("rst_cnt",    bus.retire_cnt, 0);
    check("rst_outs_h", ov_h, 20'h0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    rst_nh = 1'b1;

    drain("drain1");

    // Reset in the middle of a waiting store must drop the request at once.
    stim_q.push_back('{ins: 32'h0020A423, fw: 0, dw: 6, z: 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin seen = 1'b1; break; end
    end
    check("memwr_seen", seen, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", bus.mem_req, 1'b0);
    check("arst_we",  bus.mem_we, 1'b0);
    check("arst_cnt", bus.retire_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) stim_q.push_back(rnd_stim());
    stim_q.push_back('{ins: 32'h002081B3, fw: 0, dw: 0, z: 1'b0});
    drain("drain2");
    @(negedge clk);
    check("final_cnt", bus.retire_cnt, exp_cnt);

    check("halt_outs",   ov_h, 20'h0);
    check("halt_ill",    h_ill, 1);
    check("halt_retire", h_ret, 0);
    check("halt_fetch",  h_irw, 1);
    check("halt_cnt",    bus_h.retire_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It time-shares one ALU and one unified single-port instruction/data memory across the FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK steps. It decodes the instruction register, drives every datapath mux and enable, and handshakes with memory through mem_req/mem_ready. It also maintains a retired-instruction counter.

Parameters:
CNT_W, 32, width of retire_cnt.
ILLEGAL_HALT, 0, 1 = park in HALT on an illegal opcode; 0 = flag it and refetch.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr  in  32  instruction register contents (op = [6:0], funct3 = [14:12], funct7 = [31:25]).
zero  in  1  ALU result == 0.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access request.
mem_we  out  1  write enable, qualified by mem_req.
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
ir_write  out  1  load IR (and OldPC) from memory read data.
pc_write  out  1  PC update enable.
reg_write  out  1  register-file write enable.
alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
alu_ctrl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor.
imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B.
result_src  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result.
illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
retire  out  1  one-cycle pulse when an instruction completes.
retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Registered state; all outputs are combinational from state and instr. Outputs not listed for a state are 0.
- Reset: state = RST and retire_cnt = 0, both asynchronously; every output is 0 while in RST. RST always goes to FETCH on the next clock.
- FETCH:
  - Drives mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_ctrl = add, result_src = 10.
  - Holds while mem_ready = 0.
  - On mem_ready = 1, also drives ir_write = 1 and pc_write = 1 (PC += 4) in that same cycle, then goes to DECODE.
- DECODE: alu_src_a = 01, alu_src_b = 01, imm_src = 10, alu_ctrl = add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 with funct3 = 000 -> BEQ
  - anything else -> ILL
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_ctrl = add, imm_src = 00 for loads and 01 for stores. Goes to MEMRD for a load, MEMWR for a store.
- MEMRD: mem_req = 1, adr_src = 1. Holds until mem_ready, then goes to LDWB.
- LDWB: reg_write = 1, result_src = 01, retire = 1, then FETCH.
- MEMWR: mem_req = 1, mem_we = 1, adr_src = 1. Holds until mem_ready; retire = 1 in the mem_ready cycle, then FETCH.
- EXEC_R: alu_src_a = 10, alu_src_b = 00. alu_ctrl by funct3:
  - 000 -> add if funct7 = 0000000, sub if 0100000
  - 111 -> and
  - 110 -> or
  - 100 -> xor
  - any other funct3/funct7 -> ILL
  - Legal cases go to ALUWB.
- EXEC_I: as EXEC_R but alu_src_b = 01, imm_src = 00, and funct7 is ignored (funct3 = 000 is always add). Supports addi/andi/ori/xori; other funct3 -> ILL.
- ALUWB: reg_write = 1, result_src = 00, retire = 1, then FETCH.
- BEQ: alu_src_a = 10, alu_src_b = 00, alu_ctrl = sub, result_src = 00, pc_write = zero, retire = 1, then FETCH.
- ILL: illegal = 1, with no reg/mem/pc side effects. Goes to FETCH when ILLEGAL_HALT = 0, otherwise to HALT.
- HALT: all outputs 0; exits only by reset.
- Illegal instructions never assert retire.
- retire_cnt increments by 1 on every retire cycle and wraps modulo 2^CNT_W.
- mem_req stays high and adr_src/mem_we stay stable for every cycle of a wait. A request is never withdrawn before mem_ready.
- Reset mid-access: mem_req drops asynchronously and the fetch restarts from FETCH.
- CPI: ALU op = 4, load = 5, store = 4, beq = 3, each plus the memory wait cycles.

Test Plan:
- Reset release, mem_ready tied 1, add x3,x1,x2 (0x002081B3) -> FETCH, DECODE, EXEC_R (alu_ctrl = 000), ALUWB (reg_write = 1); retire_cnt = 1 after 4 cycles.
- lw x5,8(x1) (0x0080A283), mem_ready low for 3 cycles in both FETCH and MEMRD -> mem_req held high with adr_src stable; LDWB asserts result_src = 01 and reg_write; total 11 cycles.
- beq x1,x2 (0x00208463) with zero = 1, then zero = 0 -> pc_write = 1 in BEQ only in the first case; alu_ctrl = 001 in both.
- sub/and/or/xor and sw (0x0020A423) -> alu_ctrl = 001/010/011/100; sw gives mem_we = 1, imm_src = 01 and never asserts reg_write.
- Opcode 0x0000007F and R-type funct3 = 001 -> illegal pulse, no retire, next state FETCH; with ILLEGAL_HALT = 1, stays in HALT with all outputs 0.
- rst_n asserted mid-MEMWR -> mem_req/mem_we drop immediately and retire_cnt = 0; preset retire_cnt to all-ones via a forced run and retire -> wraps to 0.
